ghost_walker: RTL and testbench
===============================

# ghost_walker

Sequential multi-ghost movement engine for the Pac-Man maze. On each `step` strobe it walks every ghost one block, time-multiplexing a single wall-map lookup port: for each ghost it requests the 4-bit open-direction mask of its current block, picks a legal direction, and updates that ghost's position. It sits between the game tick generator and the sprite renderer, and replaces per-ghost combinational direction logic with one parametrised, scheduled engine.

## Interface
- `NUM_GHOSTS`, 4: number of ghost channels (1..8).
- `COORD_W`, 10: block coordinate width.
- `GRID_W`, 40: maze width in blocks. X wraps in 0..GRID_W-1.
- `HOME_X`, 20: reset X of ghost 0. Ghost i resets to HOME_X+i.
- `HOME_Y`, 13: reset Y of all ghosts.
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous, active-low reset
- `step`  in  1  one-cycle move request
- `pac_x`, `pac_y`  in  COORD_W each  chase target; sampled when `step` is accepted
- `frightened`  in  1  random-walk mode request; sampled when `step` is accepted
- `map_req`  out  1  map lookup strobe
- `map_x`, `map_y`  out  COORD_W each  block being queried
- `map_valid`  in  4  open-direction mask: [3]=down (y+1), [2]=up (y-1), [1]=right (x+1), [0]=left (x-1). Valid exactly one cycle after `map_req`.
- `ghost_x`, `ghost_y`  out  NUM_GHOSTS*COORD_W each  packed positions; ghost i is in slice i
- `ghost_dir`  out  NUM_GHOSTS*4  packed one-hot current direction
- `busy`  out  1  a sweep is in progress
- `done`  out  1  one-cycle pulse at the end of a sweep
- `overrun`  out  1  sticky flag: a `step` arrived while busy

## Operation
- FSM states: IDLE, REQ, WAIT, MOVE, DONE. Ghost index `idx` is 0..NUM_GHOSTS-1.
- IDLE: when `step`=1, latch the target and mode, set idx=0, go to REQ.
- REQ: drive `map_req`=1 with `map_x`/`map_y` set to the position of ghost idx. Go to WAIT.
- WAIT: register `map_valid`. Go to MOVE.
- MOVE: compute the allowed mask = mask with the reverse of the current direction cleared.
  - If the allowed mask is zero, use the full mask (dead end, so reversal is permitted).
  - If the full mask is zero, the ghost holds position and direction.
  - Otherwise select a direction, apply the move, and store it as the new direction.
  - Then increment idx. If this was the last ghost go to DONE, else go to REQ.
- DONE: pulse `done`=1 and go to IDLE.
- Chase selection: for each allowed neighbour compute the Manhattan distance |nx-tx|+|ny-ty| at COORD_W+1 bits. Pick the minimum. Ties are broken by priority up > left > down > right.
- Moves: x+1 at GRID_W-1 wraps to 0; x-1 at 0 wraps to GRID_W-1. Y does not wrap, because the map never opens past a Y edge.
- `step` is accepted only in IDLE. A `step` arriving in any other state is dropped and sets `overrun`=1, which stays set until reset.

## Timing
- Reset values (`rst_n`=0 at a clk edge):
  - state = IDLE; `busy`=0, `done`=0, `map_req`=0, `overrun`=0; `map_x`=`map_y`=0.
  - Ghost i at (HOME_X+i, HOME_Y) with `ghost_dir`=4'b0001 (left).
- Reset mid-sweep aborts the sweep immediately. Partially updated ghosts are restored to their home positions.
- `busy`=1 from the cycle after `step` is accepted until the cycle of `done`, inclusive.
- Each ghost takes 3 cycles (REQ, WAIT, MOVE). `done` is asserted 3*NUM_GHOSTS+1 cycles after the accepting edge; this is 13 cycles for the default.
- Ghost i's outputs change at the clock edge that ends its MOVE state. Other ghosts' outputs are stable.
- `step` and `done` in the same cycle: that `step` is an overrun, because the FSM is not yet back in IDLE.

## Configuration
- `GHOST_RANDOM_EN` defined:
  - Adds a 16-bit LFSR (taps 16,14,13,11; seed 16'hACE1; advances every clock, reset to seed).
  - While latched `frightened`=1, MOVE picks the first set bit of the allowed mask, scanning bit positions upward from lfsr[1:0] and wrapping.
- `GHOST_RANDOM_EN` not defined:
  - No LFSR is built, `frightened` is ignored, and chase selection is always used.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles -> ghosts at (20,13),(21,13),(22,13),(23,13); all dirs 0001; `busy`=0; `overrun`=0.
- Chase: ghost 0 at (20,13) dir left, map returns 1111, pac=(10,13) -> ghost 0 moves to (19,13) dir 0001. `done` is seen 13 cycles after `step`.
- Dead end: ghost dir left, map returns 0010 -> ghost reverses to x+1, dir 0010. Map returns 0000 -> position and dir unchanged.
- Wrap: ghost at (0,13) dir left, map 0001 -> x becomes 39. Ghost at (39,13) dir right, map 0010 -> x becomes 0.
- Overrun: second `step` 5 cycles after the first -> sweep completes normally, `overrun`=1 until reset. `rst_n`=0 mid-sweep -> home positions, `busy`=0 next cycle.
- With `GHOST_RANDOM_EN` and `frightened`=1, map 1111, dir left: over 64 sweeps, up, left and down are all taken and right is never taken.

Source files
------------

// File: rtl/ghost_walker.sv
// ghost_walker: steps every ghost one block per sweep, sharing a single wall-map lookup port.
// Define GHOST_RANDOM_EN to add an LFSR random walk used while frightened.
module ghost_walker #(
    parameter int NUM_GHOSTS = 4,
    parameter int COORD_W    = 10,
    parameter int GRID_W     = 40,
    parameter int HOME_X     = 20,
    parameter int HOME_Y     = 13
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          step,
    input  logic [COORD_W-1:0]            pac_x,
    input  logic [COORD_W-1:0]            pac_y,
    input  logic                          frightened,
    output logic                          map_req,
    output logic [COORD_W-1:0]            map_x,
    output logic [COORD_W-1:0]            map_y,
    input  logic [3:0]                    map_valid,
    output logic [NUM_GHOSTS*COORD_W-1:0] ghost_x,
    output logic [NUM_GHOSTS*COORD_W-1:0] ghost_y,
    output logic [NUM_GHOSTS*4-1:0]       ghost_dir,
    output logic                          busy,
    output logic                          done,
    output logic                          overrun,
    output logic [2:0]                    dbg_state
);

    localparam int IDX_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_GHOSTS - 1);
    localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(GRID_W - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        MOVE = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [COORD_W-1:0] r_tx;
    logic [COORD_W-1:0] r_ty;
    logic [COORD_W-1:0] r_map_x;
    logic [COORD_W-1:0] r_map_y;
    logic [3:0]         r_mask;
    logic               r_overrun;
    logic [COORD_W-1:0] r_gx   [NUM_GHOSTS];
    logic [COORD_W-1:0] r_gy   [NUM_GHOSTS];
    logic [3:0]         r_gdir [NUM_GHOSTS];

    logic [COORD_W-1:0] w_cur_x;
    logic [COORD_W-1:0] w_cur_y;
    logic [3:0]         w_cur_dir;
    logic [3:0]         w_rev;
    logic [3:0]         w_allow;
    logic [3:0]         w_use;
    logic [3:0]         w_chase;
    logic [3:0]         w_sel;
    logic [COORD_W-1:0] w_left_x;
    logic [COORD_W-1:0] w_right_x;
    logic [COORD_W-1:0] w_up_y;
    logic [COORD_W-1:0] w_down_y;
    logic [COORD_W:0]   w_d_up;
    logic [COORD_W:0]   w_d_left;
    logic [COORD_W:0]   w_d_down;
    logic [COORD_W:0]   w_d_right;
    logic [COORD_W:0]   w_best;
    logic [COORD_W-1:0] w_new_x;
    logic [COORD_W-1:0] w_new_y;

    function automatic logic [COORD_W:0] absdiff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (step) w_next = REQ;
            REQ:     w_next = WAIT;
            WAIT:    w_next = MOVE;
            MOVE:    w_next = (r_idx == LAST_IDX) ? DONE : REQ;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign map_req   = (r_state == REQ);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign dbg_state = r_state;
    assign map_x     = r_map_x;
    assign map_y     = r_map_y;
    assign overrun   = r_overrun;

    assign w_cur_x   = r_gx[r_idx];
    assign w_cur_y   = r_gy[r_idx];
    assign w_cur_dir = r_gdir[r_idx];

    // Reverse direction swaps left<->right and up<->down; a dead end falls back to the full mask.
    assign w_rev   = {w_cur_dir[2], w_cur_dir[3], w_cur_dir[0], w_cur_dir[1]};
    assign w_allow = r_mask & ~w_rev;
    assign w_use   = (w_allow != 4'b0000) ? w_allow : r_mask;

    assign w_left_x  = (w_cur_x == '0)    ? X_MAX : w_cur_x - COORD_W'(1);
    assign w_right_x = (w_cur_x == X_MAX) ? '0    : w_cur_x + COORD_W'(1);
    assign w_up_y    = w_cur_y - COORD_W'(1);
    assign w_down_y  = w_cur_y + COORD_W'(1);

    assign w_d_up    = absdiff(w_cur_x, r_tx)   + absdiff(w_up_y, r_ty);
    assign w_d_left  = absdiff(w_left_x, r_tx)  + absdiff(w_cur_y, r_ty);
    assign w_d_down  = absdiff(w_cur_x, r_tx)   + absdiff(w_down_y, r_ty);
    assign w_d_right = absdiff(w_right_x, r_tx) + absdiff(w_cur_y, r_ty);

    // Candidates are visited in tie-break priority order; only a strictly shorter distance wins.
    always_comb begin
        w_chase = 4'b0000;
        w_best  = '1;
        if (w_use[2] && (w_d_up < w_best)) begin
            w_best  = w_d_up;
            w_chase = 4'b0100;
        end
        if (w_use[0] && (w_d_left < w_best)) begin
            w_best  = w_d_left;
            w_chase = 4'b0001;
        end
        if (w_use[3] && (w_d_down < w_best)) begin
            w_best  = w_d_down;
            w_chase = 4'b1000;
        end
        if (w_use[1] && (w_d_right < w_best)) begin
            w_best  = w_d_right;
            w_chase = 4'b0010;
        end
    end

`ifdef GHOST_RANDOM_EN
    logic [15:0] r_lfsr;
    logic        r_fright;
    logic [3:0]  w_rand;
    logic [1:0]  w_pos;
    logic        w_found;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr   <= 16'hACE1;
            r_fright <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            if (r_state == IDLE && step) r_fright <= frightened;
        end
    end

    // Scan upward from lfsr[1:0], wrapping, and take the first open bit.
    always_comb begin
        w_rand  = 4'b0000;
        w_found = 1'b0;
        w_pos   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_pos = r_lfsr[1:0] + 2'(k);
            if (!w_found && w_use[w_pos]) begin
                w_found = 1'b1;
                w_rand  = 4'b0001 << w_pos;
            end
        end
    end

    assign w_sel = r_fright ? w_rand : w_chase;
`else
    logic w_unused_fright;
    assign w_unused_fright = frightened;
    assign w_sel           = w_chase;
`endif

    always_comb begin
        w_new_x = w_cur_x;
        w_new_y = w_cur_y;
        case (w_sel)
            4'b0001: w_new_x = w_left_x;
            4'b0010: w_new_x = w_right_x;
            4'b0100: w_new_y = w_up_y;
            4'b1000: w_new_y = w_down_y;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_tx      <= '0;
            r_ty      <= '0;
            r_mask    <= 4'b0000;
            r_map_x   <= '0;
            r_map_y   <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                r_gx[i]   <= COORD_W'(HOME_X + i);
                r_gy[i]   <= COORD_W'(HOME_Y);
                r_gdir[i] <= 4'b0001;
            end
        end else begin
            if (step && (r_state != IDLE)) r_overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (step) begin
                        r_tx    <= pac_x;
                        r_ty    <= pac_y;
                        r_idx   <= '0;
                        r_map_x <= r_gx[0];
                        r_map_y <= r_gy[0];
                    end
                end
                WAIT: r_mask <= map_valid;
                MOVE: begin
                    // An all-closed mask yields no selection: position and direction hold.
                    if (w_sel != 4'b0000) begin
                        r_gx[r_idx]   <= w_new_x;
                        r_gy[r_idx]   <= w_new_y;
                        r_gdir[r_idx] <= w_sel;
                    end
                    if (r_idx != LAST_IDX) begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_map_x <= r_gx[r_idx + IDX_W'(1)];
                        r_map_y <= r_gy[r_idx + IDX_W'(1)];
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_pack
        assign ghost_x[g*COORD_W +: COORD_W] = r_gx[g];
        assign ghost_y[g*COORD_W +: COORD_W] = r_gy[g];
        assign ghost_dir[g*4 +: 4]           = r_gdir[g];
    end

endmodule

// File: tb/tb_ghost_walker.sv
// Directed bench for ghost_walker: a negedge map responder serves per-ghost masks and
// checks lookup addresses against a queue; each task checks its own scenario.
module tb_ghost_walker;

    localparam int NG = 4;
    localparam int CW = 10;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               step;
    logic [CW-1:0]      pac_x;
    logic [CW-1:0]      pac_y;
    logic               frightened;
    logic               map_req;
    logic [CW-1:0]      map_x;
    logic [CW-1:0]      map_y;
    logic [3:0]         map_valid = 4'b0000;
    logic [NG*CW-1:0]   ghost_x;
    logic [NG*CW-1:0]   ghost_y;
    logic [NG*4-1:0]    ghost_dir;
    logic               busy;
    logic               done;
    logic               overrun;
    logic [2:0]         dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    logic [CW-1:0]   exp_gx [NG];
    logic [CW-1:0]   exp_gy [NG];
    logic [3:0]      exp_gd [NG];
    logic [3:0]      tb_mask[NG];
    logic [2*CW-1:0] exp_q[$];
    logic [2*CW-1:0] exp_a;
    int              req_n    = 0;
    int              pend_idx = 0;
    logic            pend     = 1'b0;

    ghost_walker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (step),
        .pac_x      (pac_x),
        .pac_y      (pac_y),
        .frightened (frightened),
        .map_req    (map_req),
        .map_x      (map_x),
        .map_y      (map_y),
        .map_valid  (map_valid),
        .ghost_x    (ghost_x),
        .ghost_y    (ghost_y),
        .ghost_dir  (ghost_dir),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // Map model: mask appears in the cycle after map_req; each lookup address is checked.
    always @(negedge clk) begin
        map_valid = pend ? tb_mask[pend_idx] : 4'b0000;
        pend      = 1'b0;
        if (map_req === 1'b1) begin
            pend     = 1'b1;
            pend_idx = req_n % NG;
            req_n++;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL map_addr: got unexpected request at (%0d,%0d) want no request", map_x, map_y);
            end else begin
                exp_a = exp_q.pop_front();
                if ({map_x, map_y} !== exp_a)
                    $display("FAIL map_addr: got (%0d,%0d) want (%0d,%0d)",
                             map_x, map_y, exp_a[2*CW-1:CW], exp_a[CW-1:0]);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic set_home();
        exp_gx = '{10'd20, 10'd21, 10'd22, 10'd23};
        exp_gy = '{10'd13, 10'd13, 10'd13, 10'd13};
        exp_gd = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
    endtask

    task automatic run_sweep(output int lat);
        req_n = 0;
        for (int g = 0; g < NG; g++) exp_q.push_back({exp_gx[g], exp_gy[g]});
        @(negedge clk);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        lat  = 1;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        set_home();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < NG; g++) begin
            n_total++;
            if (ghost_x[g*CW +: CW] !== exp_gx[g] || ghost_y[g*CW +: CW] !== exp_gy[g] || ghost_dir[g*4 +: 4] !== exp_gd[g])
                $display("FAIL reset_ghost%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)", g,
                         ghost_x[g*CW +: CW], ghost_y[g*CW +: CW], ghost_dir[g*4 +: 4], exp_gx[g], exp_gy[g], exp_gd[g]);
            else n_pass++;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_total++;
        if (map_req !== 1'b0) $display("FAIL reset_map_req: got %b want 0", map_req); else n_pass++;
        n_total++;
        if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
        n_total++;
        if (map_x !== 10'd0 || map_y !== 10'd0)
            $display("FAIL reset_map_xy: got (%0d,%0d) want (0,0)", map_x, map_y);
        else n_pass++;
        n_total++;
        if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_chase();
        int lat;
        tb_mask = '{4'b1111, 4'b0000, 4'b0000, 4'b0000};
        pac_x = 10'd10;
        pac_y = 10'd13;
        run_sweep(lat);
        exp_gx[0] = 10'd19;
        n_total++;
        if (lat !== 13) $display("FAIL chase_latency: got %0d want 13", lat); else n_pass++;
        for (int g = 0; g < NG; g++) begin
            n_total++;
            if (ghost_x[g*CW +: CW] !== exp_gx[g] || ghost_y[g*CW +: CW] !== exp_gy[g] || ghost_dir[g*4 +: 4] !== exp_gd[g])
                $display("FAIL chase_ghost%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)", g,
                         ghost_x[g*CW +: CW], ghost_y[g*CW +: CW], ghost_dir[g*4 +: 4], exp_gx[g], exp_gy[g], exp_gd[g]);
            else n_pass++;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL chase_busy_after: got %b want 0", busy); else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL chase_requests: got %0d pending want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_tie();
        int lat;
        tb_mask = '{4'b1111, 4'b1111, 4'b0000, 4'b0000};
        pac_x = 10'd21;
        pac_y = 10'd13;
        run_sweep(lat);
        exp_gy[0] = 10'd12; exp_gd[0] = 4'b0100;
        exp_gy[1] = 10'd12; exp_gd[1] = 4'b0100;
        for (int g = 0; g < NG; g++) begin
            n_total++;
            if (ghost_x[g*CW +: CW] !== exp_gx[g] || ghost_y[g*CW +: CW] !== exp_gy[g] || ghost_dir[g*4 +: 4] !== exp_gd[g])
                $display("FAIL tie_ghost%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)", g,
                         ghost_x[g*CW +: CW], ghost_y[g*CW +: CW], ghost_dir[g*4 +: 4], exp_gx[g], exp_gy[g], exp_gd[g]);
            else n_pass++;
        end
    endtask

    task automatic test_dead_end();
        int lat;
        tb_mask = '{4'b0000, 4'b0000, 4'b0010, 4'b1000};
        run_sweep(lat);
        exp_gx[2] = 10'd23; exp_gd[2] = 4'b0010;
        exp_gy[3] = 10'd14; exp_gd[3] = 4'b1000;
        for (int g = 0; g < NG; g++) begin
            n_total++;
            if (ghost_x[g*CW +: CW] !== exp_gx[g] || ghost_y[g*CW +: CW] !== exp_gy[g] || ghost_dir[g*4 +: 4] !== exp_gd[g])
                $display("FAIL dead_end_ghost%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)", g,
                         ghost_x[g*CW +: CW], ghost_y[g*CW +: CW], ghost_dir[g*4 +: 4], exp_gx[g], exp_gy[g], exp_gd[g]);
            else n_pass++;
        end
        tb_mask = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        run_sweep(lat);
        for (int g = 0; g < NG; g++) begin
            n_total++;
            if (ghost_x[g*CW +: CW] !== exp_gx[g] || ghost_y[g*CW +: CW] !== exp_gy[g] || ghost_dir[g*4 +: 4] !== exp_gd[g])
                $display("FAIL closed_ghost%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)", g,
                         ghost_x[g*CW +: CW], ghost_y[g*CW +: CW], ghost_dir[g*4 +: 4], exp_gx[g], exp_gy[g], exp_gd[g]);
            else n_pass++;
        end
        // Left would be closer to the target, but it is the reverse of the current direction.
        tb_mask = '{4'b0000, 4'b0000, 4'b0011, 4'b0000};
        run_sweep(lat);
        exp_gx[2] = 10'd24;
        n_total++;
        if (ghost_x[2*CW +: CW] !== exp_gx[2] || ghost_dir[2*4 +: 4] !== exp_gd[2])
            $display("FAIL no_reverse: got (%0d,%b) want (%0d,%b)", ghost_x[2*CW +: CW], ghost_dir[2*4 +: 4], exp_gx[2], exp_gd[2]);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int lat;
        tb_mask = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 19; i++) begin
            run_sweep(lat);
            exp_gx[0] = 10'(18 - i);
            exp_gd[0] = 4'b0001;
        end
        n_total++;
        if (ghost_x[0 +: CW] !== 10'd0 || ghost_y[0 +: CW] !== 10'd12)
            $display("FAIL wrap_reach_zero: got (%0d,%0d) want (0,12)", ghost_x[0 +: CW], ghost_y[0 +: CW]);
        else n_pass++;
        run_sweep(lat);
        exp_gx[0] = 10'd39;
        n_total++;
        if (ghost_x[0 +: CW] !== 10'd39 || ghost_dir[0 +: 4] !== 4'b0001)
            $display("FAIL wrap_left: got (%0d,%b) want (39,0001)", ghost_x[0 +: CW], ghost_dir[0 +: 4]);
        else n_pass++;
        tb_mask = '{4'b0010, 4'b0000, 4'b0000, 4'b0000};
        run_sweep(lat);
        exp_gx[0] = 10'd0; exp_gd[0] = 4'b0010;
        n_total++;
        if (ghost_x[0 +: CW] !== 10'd0 || ghost_dir[0 +: 4] !== 4'b0010)
            $display("FAIL wrap_right: got (%0d,%b) want (0,0010)", ghost_x[0 +: CW], ghost_dir[0 +: 4]);
        else n_pass++;
        run_sweep(lat);
        exp_gx[0] = 10'd1;
        n_total++;
        if (ghost_x[0 +: CW] !== 10'd1 || ghost_dir[0 +: 4] !== 4'b0010)
            $display("FAIL right_step: got (%0d,%b) want (1,0010)", ghost_x[0 +: CW], ghost_dir[0 +: 4]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        tb_mask = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        req_n = 0;
        for (int g = 0; g < NG; g++) exp_q.push_back({exp_gx[g], exp_gy[g]});
        @(negedge clk);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        lat  = 1;
        n_total++;
        if (busy !== 1'b1) $display("FAIL b2b_busy_start: got %b want 1", busy); else n_pass++;
        repeat (4) begin
            @(posedge clk); #1;
            lat++;
        end
        @(negedge clk);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        lat++;
        n_total++;
        if (overrun !== 1'b1) $display("FAIL b2b_overrun_set: got %b want 1", overrun); else n_pass++;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        n_total++;
        if (lat !== 13) $display("FAIL b2b_latency: got %0d want 13", lat); else n_pass++;
        repeat (4) @(posedge clk);
        #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL b2b_no_second_sweep: got busy %b want 0", busy); else n_pass++;
        n_total++;
        if (overrun !== 1'b1) $display("FAIL b2b_overrun_sticky: got %b want 1", overrun); else n_pass++;
    endtask

    task automatic test_reset_mid();
        tb_mask = '{4'b1111, 4'b0000, 4'b0000, 4'b0000};
        pac_x = 10'd10;
        pac_y = 10'd13;
        req_n = 0;
        for (int g = 0; g < NG; g++) exp_q.push_back({exp_gx[g], exp_gy[g]});
        @(negedge clk);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Down and right tie at distance 9; down has priority.
        n_total++;
        if (ghost_x[0 +: CW] !== 10'd1 || ghost_y[0 +: CW] !== 10'd13 || ghost_dir[0 +: 4] !== 4'b1000)
            $display("FAIL mid_tie_down: got (%0d,%0d,%b) want (1,13,1000)",
                     ghost_x[0 +: CW], ghost_y[0 +: CW], ghost_dir[0 +: 4]);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        set_home();
        n_total++;
        if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", busy); else n_pass++;
        n_total++;
        if (overrun !== 1'b0) $display("FAIL mid_reset_overrun: got %b want 0", overrun); else n_pass++;
        for (int g = 0; g < NG; g++) begin
            n_total++;
            if (ghost_x[g*CW +: CW] !== exp_gx[g] || ghost_y[g*CW +: CW] !== exp_gy[g] || ghost_dir[g*4 +: 4] !== exp_gd[g])
                $display("FAIL mid_reset_ghost%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)", g,
                         ghost_x[g*CW +: CW], ghost_y[g*CW +: CW], ghost_dir[g*4 +: 4], exp_gx[g], exp_gy[g], exp_gd[g]);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_step_at_done();
        int lat;
        tb_mask = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        req_n = 0;
        for (int g = 0; g < NG; g++) exp_q.push_back({exp_gx[g], exp_gy[g]});
        @(negedge clk);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        lat  = 1;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        n_total++;
        if (lat !== 13) $display("FAIL done_latency: got %0d want 13", lat); else n_pass++;
        @(negedge clk);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        n_total++;
        if (overrun !== 1'b1) $display("FAIL done_step_overrun: got %b want 1", overrun); else n_pass++;
        n_total++;
        if (dbg_state !== 3'd0) $display("FAIL done_step_state: got %0d want 0", dbg_state); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL done_step_ignored: got busy %b want 0", busy); else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frightened();
        int lat;
`ifdef GHOST_RANDOM_EN
        logic seen_up, seen_left, seen_down, seen_right;
        seen_up = 1'b0; seen_left = 1'b0; seen_down = 1'b0; seen_right = 1'b0;
        tb_mask    = '{4'b1111, 4'b0000, 4'b0000, 4'b0000};
        frightened = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            set_home();
            repeat (k) @(negedge clk);
            run_sweep(lat);
            if (ghost_dir[0 +: 4] == 4'b0100) seen_up    = 1'b1;
            if (ghost_dir[0 +: 4] == 4'b0001) seen_left  = 1'b1;
            if (ghost_dir[0 +: 4] == 4'b1000) seen_down  = 1'b1;
            if (ghost_dir[0 +: 4] == 4'b0010) seen_right = 1'b1;
        end
        n_total++;
        if (seen_up !== 1'b1) $display("FAIL rand_up: got %b want 1", seen_up); else n_pass++;
        n_total++;
        if (seen_left !== 1'b1) $display("FAIL rand_left: got %b want 1", seen_left); else n_pass++;
        n_total++;
        if (seen_down !== 1'b1) $display("FAIL rand_down: got %b want 1", seen_down); else n_pass++;
        n_total++;
        if (seen_right !== 1'b0) $display("FAIL rand_right: got %b want 0", seen_right); else n_pass++;
`else
        set_home();
        tb_mask    = '{4'b1111, 4'b0000, 4'b0000, 4'b0000};
        frightened = 1'b1;
        pac_x = 10'd10;
        pac_y = 10'd13;
        run_sweep(lat);
        n_total++;
        if (ghost_x[0 +: CW] !== 10'd19 || ghost_y[0 +: CW] !== 10'd13 || ghost_dir[0 +: 4] !== 4'b0001)
            $display("FAIL fright_ignored: got (%0d,%0d,%b) want (19,13,0001)",
                     ghost_x[0 +: CW], ghost_y[0 +: CW], ghost_dir[0 +: 4]);
        else n_pass++;
`endif
        frightened = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        step       = 1'b0;
        frightened = 1'b0;
        pac_x      = '0;
        pac_y      = '0;
        tb_mask    = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        test_reset();
        test_chase();
        test_tie();
        test_dead_end();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_step_at_done();
        test_frightened();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
